avst_packet_fifo: RTL
=====================

# avst_packet_fifo

Store-and-forward Avalon-ST packet buffer placed directly downstream of `multiplexer`, taking its `avso_*` stream. It emits a packet only once the whole packet, through EOP, is buffered, so the output never stalls mid-packet waiting on input. It also enforces packet framing: oversize, truncated and orphan data are dropped and counted.

## Interface
- `channel_width`, 10: channel field width.
- `data_width`, 32: data bus width.
- `empty_width`, 2: empty field width, equal to `$clog2(data_width/8)`.
- `addr_width`, 10: buffer depth is DEPTH = 2^addr_width words, which is also the maximum packet length.
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `avsi_channel`, `avsi_data`, `avsi_valid`, `avsi_sop`, `avsi_eop`, `avsi_empty`  in  per params  sink stream.
- `avsi_ready`  out  1  sink backpressure.
- `avso_channel`, `avso_data`, `avso_valid`, `avso_sop`, `avso_eop`, `avso_empty`  out  per params  source stream.
- `avso_ready`  in  1  source backpressure.
- `stat_drop_pkts`  out  16  oversize packets dropped; saturates at 0xFFFF.
- `stat_frame_errs`  out  16  framing errors; saturates at 0xFFFF.
- `fill_level`  out  addr_width+1  words in RAM, committed plus in-progress.

## Operation
- **Handshake:** readyLatency 0. A transfer occurs on a rising edge with valid=1 and ready=1.
  - Idle cycles inside a packet (valid=0) are legal on both sides.
  - `avso_*` hold stable while avso_valid=1 and avso_ready=0.
- **Stored word:** {channel, data, sop, eop, empty}, stored per beat.
- **Pointers:** each is addr_width+1 bits and wraps naturally.
  - `wr_cur` is the speculative write pointer.
  - `wr_ptr` is the committed write pointer.
  - `rd_ptr` is the read pointer.
  - Occupancy = wr_cur − rd_ptr; full when occupancy == DEPTH.
- **Write FSM states:**
  - IDLE
    - accepted word with sop=1, eop=1 is written and committed (wr_ptr ← wr_cur+1); stay in IDLE.
    - accepted word with sop=1, eop=0 is written; go to PKT.
    - accepted word with sop=0 is discarded and stat_frame_errs increments, once per orphan word.
  - PKT
    - accepted non-sop word is written.
    - a word with eop=1 is written and committed; go to IDLE.
    - a word with sop=1 means truncation: wr_cur rewinds to wr_ptr, stat_frame_errs increments, and the new word is written as the start of a fresh packet. The next state follows the IDLE rules for that word.
    - oversize: occupancy == DEPTH while committed packet count == 0. On the next edge, rewind wr_cur to wr_ptr, increment stat_drop_pkts and go to DROP.
  - DROP
    - avsi_ready=1; all words are discarded.
    - the word with eop=1 returns the FSM to IDLE.
    - a word with sop=1 goes to PKT (or IDLE if it also has eop=1) and is written.
- **avsi_ready:**
  - IDLE or PKT: high when not full.
  - DROP: always high.
  - 0 during reset.
  - Driven from registered state only; no combinational path from avso_ready.
- **Read side:**
  - `pkt_cnt` counts committed packets not yet fully read from RAM. It increments on commit and decrements when an eop word is read from RAM. Simultaneous increment and decrement leave it unchanged.
  - The read path prefetches through a one-entry output register.
  - Words are read only while pkt_cnt > 0.
- **Reset:**
  - All pointers, pkt_cnt, FSM (to IDLE), counters, fill_level, avso_valid/sop/eop, and the channel/data/empty output registers are cleared to 0.
  - Asserting reset mid-packet flushes all buffered data.

## Timing
- If the EOP is accepted at edge N with the output register empty, avso_valid=1 with SOP appears after edge N+1.
- Sustained throughput is 1 word/cycle in each direction, including back-to-back packets: no bubble between one packet's EOP and the next packet's SOP when already committed.
- Space freed by a read at edge N is reflected in avsi_ready after edge N.
- A packet of exactly DEPTH words is accepted; a DEPTH+1 word packet is dropped.
- stat_* and fill_level are registered and update one edge after the causing event.

## Structure
- Package `avst_pkg` holds:
  - the write-FSM enum {IDLE, PKT, DROP};
  - default width localparams;
  - the counter width localparam (16).
- Sub-module `avst_fifo_ram`: simple dual-port RAM, one write port and one registered read port, DEPTH × (channel_width + data_width + empty_width + 2).
- Top level holds the FSM, pointers, pkt_cnt, prefetch/output register and statistics.

## Test plan
- **Single-word packet:** sop=eop=1, channel 0x155, data 0xDEADBEEF, avso_ready=1.
  - Output carries the same word with avso_valid after edge N+1.
  - stat_* remain 0.
- **Long gapped packet:** 1000-word packet, random avsi_valid gaps, avso_ready toggling every cycle.
  - Output matches word-for-word.
  - avso_valid stays 0 until the EOP is accepted.
  - Output holds stable under backpressure.
- **Back-to-back packets:** three 5-word packets, avso_ready=1.
  - 15 consecutive output beats with no gaps.
  - fill_level returns to 0.
- **Oversize drop:** addr_width=4.
  - A 16-word packet passes.
  - A 20-word packet is dropped with stat_drop_pkts=1.
  - A following 3-word packet (channel 0x3) is delivered intact.
- **Framing errors:**
  - Inject sop at word 4 of a 10-word packet: only the second packet appears, stat_frame_errs=1.
  - Then send 2 orphan words in IDLE: stat_frame_errs=3, nothing is output.
- **Reset mid-packet:** assert reset_n=0 after 7 of 12 words.
  - All outputs are 0 and fill_level=0.
  - After release, a fresh 4-word packet passes correctly.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared types and default widths for the Avalon-ST store-and-forward packet buffer.
package avst_pkg;
    localparam int CHANNEL_W_DEF = 10;
    localparam int DATA_W_DEF    = 32;
    localparam int EMPTY_W_DEF   = 2;
    localparam int ADDR_W_DEF    = 10;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;
endpackage

// File: rtl/avst_fifo_ram.sv
// Simple dual-port buffer RAM: one write port, one read port with an enabled output register.
module avst_fifo_ram
    import avst_pkg::*;
#(
    parameter int addr_width = ADDR_W_DEF,
    parameter int word_width = CHANNEL_W_DEF + DATA_W_DEF + EMPTY_W_DEF + 2
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [word_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [word_width-1:0] rd_data
);
    logic [word_width-1:0] mem [2**addr_width];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the stream output register, so it holds when not enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/avst_packet_fifo.sv
// Store-and-forward Avalon-ST packet buffer: releases a packet only once its EOP is stored,
// and drops oversize, truncated and orphan data while counting them.
module avst_packet_fifo
    import avst_pkg::*;
#(
    parameter int channel_width = CHANNEL_W_DEF,
    parameter int data_width    = DATA_W_DEF,
    parameter int empty_width   = EMPTY_W_DEF,
    parameter int addr_width    = ADDR_W_DEF
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [channel_width-1:0] avsi_channel,
    input  logic [data_width-1:0]    avsi_data,
    input  logic                     avsi_valid,
    input  logic                     avsi_sop,
    input  logic                     avsi_eop,
    input  logic [empty_width-1:0]   avsi_empty,
    output logic                     avsi_ready,
    output logic [channel_width-1:0] avso_channel,
    output logic [data_width-1:0]    avso_data,
    output logic                     avso_valid,
    output logic                     avso_sop,
    output logic                     avso_eop,
    output logic [empty_width-1:0]   avso_empty,
    input  logic                     avso_ready,
    output logic [CNT_W-1:0]         stat_drop_pkts,
    output logic [CNT_W-1:0]         stat_frame_errs,
    output logic [addr_width:0]      fill_level
);
    localparam int WORD_W = channel_width + data_width + empty_width + 2;
    localparam logic [addr_width:0] DEPTH   = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0] PTR_ONE = {{addr_width{1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    wr_state_e           state;
    logic [addr_width:0] wr_cur, wr_ptr, rd_ptr, occ, waddr, pkt_cnt;
    logic [CNT_W-1:0]    drop_cnt, err_cnt;
    logic                run;
    logic                full, accept, wr_start, wr_cont, orphan, trunc, sop_lost;
    logic                oversize, we, commit;
    logic                can_rd, rd_en, rd_ld_p0, rd_eop_p0;
    logic [WORD_W-1:0]   wr_word, rd_word;

    assign occ        = wr_cur - rd_ptr;
    assign full       = (occ == DEPTH);
    assign avsi_ready = run & ((state == ST_DROP) | ~full);
    assign accept     = avsi_valid & avsi_ready;

    // A SOP can only arrive while full in DROP; it cannot be stored, so that packet is lost too.
    assign sop_lost = accept & avsi_sop & full;
    assign wr_start = accept & avsi_sop & ~full;
    assign wr_cont  = accept & ~avsi_sop & (state == ST_PKT);
    assign orphan   = accept & ~avsi_sop & (state == ST_IDLE);
    assign trunc    = wr_start & (state == ST_PKT);
    assign oversize = (state == ST_PKT) & full & (pkt_cnt == '0);
    assign we       = wr_start | wr_cont;
    assign waddr    = wr_start ? wr_ptr : wr_cur;
    assign commit   = we & avsi_eop;
    assign wr_word  = {avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wr_cur   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (oversize) begin
                wr_cur <= wr_ptr;
                state  <= ST_DROP;
            end else if (we) begin
                wr_cur <= waddr + PTR_ONE;
                if (avsi_eop) begin
                    wr_ptr <= waddr + PTR_ONE;
                    state  <= ST_IDLE;
                end else begin
                    state  <= ST_PKT;
                end
            end else if (accept && avsi_eop && state == ST_DROP) begin
                state <= ST_IDLE;
            end
            if (oversize || sop_lost) drop_cnt <= sat_inc(drop_cnt);
            if (trunc || orphan)      err_cnt  <= sat_inc(err_cnt);
        end
    end

    // Read stage p0: RAM output register is the source stream register.
    assign can_rd    = (pkt_cnt != '0) & (rd_ptr != wr_ptr);
    assign rd_en     = can_rd & (~avso_valid | avso_ready);
    assign rd_eop_p0 = rd_word[empty_width];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            avso_valid <= 1'b0;
            rd_ld_p0   <= 1'b0;
            pkt_cnt    <= '0;
            fill_level <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            avso_valid <= rd_en | (avso_valid & ~avso_ready);
            rd_ld_p0   <= rd_en;
            case ({commit, rd_ld_p0 & rd_eop_p0})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
            fill_level <= occ;
        end
    end

    avst_fifo_ram #(
        .addr_width (addr_width),
        .word_width (WORD_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (we),
        .wr_addr (waddr[addr_width-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[addr_width-1:0]),
        .rd_data (rd_word)
    );

    assign avso_channel    = rd_word[WORD_W-1 -: channel_width];
    assign avso_data       = rd_word[empty_width+2 +: data_width];
    assign avso_sop        = rd_word[empty_width+1];
    assign avso_eop        = rd_word[empty_width];
    assign avso_empty      = rd_word[empty_width-1:0];
    assign stat_drop_pkts  = drop_cnt;
    assign stat_frame_errs = err_cnt;
endmodule
